// File: rtl/dmem_resp_ctrl.sv
// Multi-cycle RV32I data-memory responder with wait states and fault reporting.
// Define DMEM_RESP_STATS_EN to enable the completed-load/store counters.
module dmem_resp_ctrl #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        W_en,
   input  logic        R_en,
   input  logic [31:0] addr,
   input  logic [2:0]  RW_type,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        ready,
   output logic        misalign_err,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [3:0] WC_M1  = 4'(WAIT_CYCLES - 1);

   logic [1:0]    r_state;
   logic [3:0]    r_wcnt;
   logic [AW+1:0] r_addr;
   logic [2:0]    r_type;
   logic [31:0]   r_din;
   logic          r_we;
   logic          r_re;
   logic [31:0]   r_mem [DEPTH_WORDS];
   logic [31:0]   r_dout;
   logic          r_ready;
   logic          r_err;

   logic [AW-1:0] w_idx;
   logic [31:0]   w_word;
   logic          w_err;
   logic          w_unused_addr;

   // High address bits alias onto the array and are intentionally dropped.
   assign w_unused_addr = ^addr[31:AW+2];
   assign w_idx  = r_addr[AW+1:2];
   assign w_word = r_mem[w_idx];

   function automatic logic [31:0] f_load(input logic [31:0] word, input logic [2:0] typ,
                                          input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (typ)
         3'b000:  f_load = {{24{b[7]}}, b};
         3'b100:  f_load = {24'd0, b};
         3'b001:  f_load = {{16{h[15]}}, h};
         3'b101:  f_load = {16'd0, h};
         3'b010:  f_load = word;
         default: f_load = 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] f_store(input logic [31:0] old, input logic [31:0] data,
                                           input logic [2:0] typ, input logic [1:0] off);
      f_store = old;
      case (typ)
         3'b000: begin
            case (off)
               2'd0:    f_store[7:0]   = data[7:0];
               2'd1:    f_store[15:8]  = data[7:0];
               2'd2:    f_store[23:16] = data[7:0];
               default: f_store[31:24] = data[7:0];
            endcase
         end
         3'b001: begin
            if (off[1]) f_store[31:16] = data[15:0];
            else        f_store[15:0]  = data[15:0];
         end
         3'b010:  f_store = data;
         default: f_store = old;
      endcase
   endfunction

   always_comb begin
      w_err = 1'b0;
      if (r_we && r_re) w_err = 1'b1;
      case (r_type)
         3'b000, 3'b100: ;
         3'b001, 3'b101: if (r_addr[0]) w_err = 1'b1;
         3'b010:         if (r_addr[1:0] != 2'b00) w_err = 1'b1;
         default:        w_err = 1'b1;
      endcase
      if (r_we && (r_type == 3'b100 || r_type == 3'b101)) w_err = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_wcnt  <= 4'd0;
         r_dout  <= 32'd0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (W_en || R_en) begin
                  r_addr  <= addr[AW+1:0];
                  r_type  <= RW_type;
                  r_din   <= din;
                  r_we    <= W_en;
                  r_re    <= R_en;
                  r_wcnt  <= WC_M1;
                  r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               if (r_wcnt == 4'd0) r_state <= S_RESP;
               else                r_wcnt  <= r_wcnt - 4'd1;
            end
            S_RESP: begin
               r_ready <= 1'b1;
               r_err   <= w_err;
               r_dout  <= (w_err || !r_re) ? 32'd0 : f_load(w_word, r_type, r_addr[1:0]);
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Storage is never cleared; a reset on the RESP edge discards the store.
   always_ff @(posedge clk) begin
      if (!reset && r_state == S_RESP && r_we && !w_err)
         r_mem[w_idx] <= f_store(w_word, r_din, r_type, r_addr[1:0]);
   end

`ifdef DMEM_RESP_STATS_EN
   logic [31:0] r_rd_cnt;
   logic [31:0] r_wr_cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_cnt <= 32'd0;
         r_wr_cnt <= 32'd0;
      end else if (r_state == S_RESP && !w_err) begin
         if (r_re) r_rd_cnt <= r_rd_cnt + 32'd1;
         else      r_wr_cnt <= r_wr_cnt + 32'd1;
      end
   end
   assign rd_count = r_rd_cnt;
   assign wr_count = r_wr_cnt;
`else
   assign rd_count = 32'd0;
   assign wr_count = 32'd0;
`endif

   assign dout         = r_dout;
   assign ready        = r_ready;
   assign misalign_err = r_err;
endmodule
